// File: rtl/ray_tri_sweep.sv
// ray_tri_sweep
// Per-ray triangle sweep controller. Accepts one ray, streams triangles
// 0..N-1 out of a synchronous triangle memory (one per cycle), registers each
// triangle next to the latched ray for a combinational intersection stage, and
// keeps the nearest valid hit. The result goes out over a valid/ready handshake.
// All geometry is signed Q16.16.
//
// Ports
//   i_clk, rst                   clock (rising edge), async active-low reset
//   i_ray_valid / o_ray_ready    ray request handshake (ready only in IDLE)
//   i_ray, i_num_tris            ray {origin, direction} and triangle count
//   o_tri_rd, o_tri_addr         triangle memory read strobe / index
//   i_tri_rdata                  triangle vertices, valid one cycle after read
//   o_isect_triangle/o_isect_ray operands for the intersection stage
//   i_isect_*                    intersection stage result for the operands
//   o_hit_valid / i_hit_ready    result handshake
//   o_hit, o_hit_idx, o_hit_t,
//   o_hit_normal, o_invalid_cnt  nearest-hit result and invalid-triangle count
module ray_tri_sweep #(
  parameter int MAX_TRIS = 1024,
  parameter int IDX_W    = 10
) (
  input  logic                     i_clk,
  input  logic                     rst,
  input  logic                     i_ray_valid,
  output logic                     o_ray_ready,
  input  logic [0:1][0:2][31:0]    i_ray,
  input  logic [IDX_W:0]           i_num_tris,
  output logic                     o_tri_rd,
  output logic [IDX_W-1:0]         o_tri_addr,
  input  logic [0:2][0:2][31:0]    i_tri_rdata,
  output logic [0:2][0:2][31:0]    o_isect_triangle,
  output logic [0:1][0:2][31:0]    o_isect_ray,
  input  logic                     i_isect_result,
  input  logic                     i_isect_invalid,
  input  logic [0:2][31:0]         i_isect_normal,
  input  logic [31:0]              i_isect_t,
  output logic                     o_hit_valid,
  input  logic                     i_hit_ready,
  output logic                     o_hit,
  output logic [IDX_W-1:0]         o_hit_idx,
  output logic [31:0]              o_hit_t,
  output logic [0:2][31:0]         o_hit_normal,
  output logic [IDX_W:0]           o_invalid_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [IDX_W:0] MAX_N   = (IDX_W+1)'(MAX_TRIS);
  localparam logic [IDX_W:0] CNT_MAX = '1;

  // Saturating increment for the invalid-triangle counter.
  function automatic logic [IDX_W:0] sat_inc(input logic [IDX_W:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + {{IDX_W{1'b0}}, 1'b1};
    end
  endfunction

  state_e                  state_q, state_d;
  logic [0:1][0:2][31:0]   ray_q, ray_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic                    rd_q, rd_d;
  logic [IDX_W-1:0]        addr_q, addr_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]        s1_idx_q, s1_idx_d;
  logic [0:2][0:2][31:0]   tri_q, tri_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [IDX_W-1:0]        s2_idx_q, s2_idx_d;
  logic                    hit_q, hit_d;
  logic [IDX_W-1:0]        best_idx_q, best_idx_d;
  logic [31:0]             best_t_q, best_t_d;
  logic [0:2][31:0]        best_nrm_q, best_nrm_d;
  logic [IDX_W:0]          inv_cnt_q, inv_cnt_d;
  logic                    ready_q, ready_d;
  logic                    hit_valid_q, hit_valid_d;
  logic [IDX_W:0]          n_clamp_s;

  assign n_clamp_s = (i_num_tris > MAX_N) ? MAX_N : i_num_tris;

  // Next-state, pipeline advance and nearest-hit tracking.
  always_comb begin
    state_d     = state_q;
    ray_d       = ray_q;
    last_d      = last_q;
    rd_d        = 1'b0;
    addr_d      = addr_q;
    hit_d       = hit_q;
    best_idx_d  = best_idx_q;
    best_t_d    = best_t_q;
    best_nrm_d  = best_nrm_q;
    inv_cnt_d   = inv_cnt_q;

    // Stage 1 mirrors the read in flight; stage 2 holds the triangle being
    // presented to the intersection stage.
    s1_valid_d  = rd_q;
    s1_idx_d    = addr_q;
    s2_valid_d  = s1_valid_q;
    s2_idx_d    = s1_idx_q;
    if (s1_valid_q) begin
      tri_d = i_tri_rdata;
    end else begin
      tri_d = tri_q;
    end

    // Strict less-than keeps the earlier (lower) index on equal t.
    if (s2_valid_q) begin
      if (i_isect_invalid) begin
        inv_cnt_d = sat_inc(inv_cnt_q);
      end else if (i_isect_result &&
                   (!hit_q || ($signed(i_isect_t) < $signed(best_t_q)))) begin
        hit_d      = 1'b1;
        best_idx_d = s2_idx_q;
        best_t_d   = i_isect_t;
        best_nrm_d = i_isect_normal;
      end else begin
        hit_d = hit_q;
      end
    end else begin
      hit_d = hit_q;
    end

    case (state_q)
      IDLE: begin
        if (i_ray_valid) begin
          ray_d      = i_ray;
          last_d     = IDX_W'(n_clamp_s - {{IDX_W{1'b0}}, 1'b1});
          hit_d      = 1'b0;
          best_idx_d = '0;
          best_t_d   = 32'd0;
          best_nrm_d = '0;
          inv_cnt_d  = '0;
          if (n_clamp_s == '0) begin
            state_d = DONE;
          end else begin
            state_d = SWEEP;
            rd_d    = 1'b1;
            addr_d  = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SWEEP: begin
        if (addr_q == last_q) begin
          state_d = DRAIN;
        end else begin
          rd_d   = 1'b1;
          addr_d = addr_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      DRAIN: begin
        // Stage 1 empty means the triangle in stage 2 (if any) is the last.
        if (!s1_valid_q) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (i_hit_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d     = (state_d == IDLE);
    hit_valid_d = (state_d == DONE);
  end

  // State, pipeline and result registers.
  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ray_q       <= '0;
      last_q      <= '0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      tri_q       <= '0;
      s2_valid_q  <= 1'b0;
      s2_idx_q    <= '0;
      hit_q       <= 1'b0;
      best_idx_q  <= '0;
      best_t_q    <= 32'd0;
      best_nrm_q  <= '0;
      inv_cnt_q   <= '0;
      ready_q     <= 1'b1;
      hit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ray_q       <= ray_d;
      last_q      <= last_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      s1_valid_q  <= s1_valid_d;
      s1_idx_q    <= s1_idx_d;
      tri_q       <= tri_d;
      s2_valid_q  <= s2_valid_d;
      s2_idx_q    <= s2_idx_d;
      hit_q       <= hit_d;
      best_idx_q  <= best_idx_d;
      best_t_q    <= best_t_d;
      best_nrm_q  <= best_nrm_d;
      inv_cnt_q   <= inv_cnt_d;
      ready_q     <= ready_d;
      hit_valid_q <= hit_valid_d;
    end
  end

  assign o_ray_ready      = ready_q;
  assign o_tri_rd         = rd_q;
  assign o_tri_addr       = addr_q;
  assign o_isect_triangle = tri_q;
  assign o_isect_ray      = ray_q;
  assign o_hit_valid      = hit_valid_q;
  assign o_hit            = hit_q;
  assign o_hit_idx        = best_idx_q;
  assign o_hit_t          = best_t_q;
  assign o_hit_normal     = best_nrm_q;
  assign o_invalid_cnt    = inv_cnt_q;

endmodule
